// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// EX-stage forwarding-mux select values.
// Latency: n/a (types only). Backpressure: n/a.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from MEM/WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from EX/MEM result

endpackage

// File: rtl/fwd_unit.sv
// Forwarding compare for one EX operand: picks the youngest in-flight writer
// of the source register, never forwarding x0.
// Latency: combinational. Backpressure: none.
// Ports: ex_rs (operand source reg), mem_rd/mem_reg_write (EX/MEM writer),
//        wb_rd/wb_reg_write (MEM/WB writer), sel (mux select).
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            sel
);

  // EX/MEM is checked first: it holds the more recent write to the register.
  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard control: stage-register enables/flushes, PC enable and EX
// forwarding selects; load-use stall, taken-branch flush, dmem-wait freeze with
// watchdog, saturating stall/flush counters.
// Latency: all control outputs combinational (same-cycle); state/counters update on clk.
// Backpressure: a dmem-not-ready load in MEM freezes PC and IF..EX/MEM, bubbles MEM/WB.
// Ports: clk, reset (async active-low); id_*/ex_*/mem_*/wb_* stage fields;
//        *_en / *_flush stage controls; fwd_a/fwd_b; err; stall_cnt, flush_cnt.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_read,
  input  logic                  dmem_ready,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int WCNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic mem_wait;
  logic freeze;
  logic load_use;
  logic stall_inc;
  logic flush_inc;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign mem_wait = mem_mem_read && !dmem_ready;
  assign freeze   = (state == ERR) || mem_wait;
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                     (id_uses_rs2 && (ex_rd == id_rs2)));

  // A load-use that coincides with a taken branch is squashed by the flush,
  // so it does not count as a stall cycle.
  assign stall_inc = freeze || (load_use && !ex_branch_taken);
  assign flush_inc = !freeze && ex_branch_taken;
  assign err       = (state == ERR);

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a_raw)
  );

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b_raw)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // wait_cnt holds the number of not-ready cycles already seen in this wait;
  // the first one is consumed by the RUN->WAIT transition.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        wait_cnt_nxt = '0;
        if (mem_wait) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = WCNT_W'(1);
        end
      end
      WAIT: begin
        // Leaving on any cycle without an outstanding wait keeps the FSM from
        // sticking if the load disappears from MEM without a ready.
        if (!mem_wait) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WCNT_W'(MAX_WAIT - 1)) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WCNT_W'(1);
        end
      end
      ERR: state_nxt = ERR;
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;
    if (!reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end else if (freeze) begin
      // Hold everything upstream of MEM; a branch or load-use sitting in the
      // frozen registers is serviced on the first unfrozen cycle.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      // Hold IF/ID and PC, inject one bubble into ID/EX.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes hand-computed
// expectations per cycle, a monitor pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] C_NORM = 7'b1111_000;
  localparam logic [6:0] C_FRZ  = 7'b0000_001;
  localparam logic [6:0] C_BR   = 7'b1111_110;
  localparam logic [6:0] C_LU   = 7'b0011_010;
  localparam logic [6:0] C_RST  = 7'b0000_111;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       mem_reg_write, mem_mem_read, dmem_ready, wb_reg_write;
  logic       pc_en, ifid_en, idex_en, exmem_en;
  logic       ifid_flush, idex_flush, memwb_flush;
  logic [1:0] fwd_a, fwd_b;
  logic       err;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      nm;
    logic [6:0] c;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       e;
    int         st;
    int         fl;
  } exp_t;

  exp_t sbq[$];

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32), .MAX_WAIT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_rd          (mem_rd),
    .mem_reg_write   (mem_reg_write),
    .mem_mem_read    (mem_mem_read),
    .dmem_ready      (dmem_ready),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_flush     (memwb_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .err             (err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    forever begin
      exp_t x;
      @(negedge clk);
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        cmp(x.nm, "ctrl", {25'd0, pc_en, ifid_en, idex_en, exmem_en,
                           ifid_flush, idex_flush, memwb_flush}, {25'd0, x.c});
        cmp(x.nm, "fwd_a", {30'd0, fwd_a}, {30'd0, x.fa});
        cmp(x.nm, "fwd_b", {30'd0, fwd_b}, {30'd0, x.fb});
        cmp(x.nm, "err", {31'd0, err}, {31'd0, x.e});
        if (x.st >= 0) cmp(x.nm, "stall_cnt", stall_cnt, x.st);
        if (x.fl >= 0) cmp(x.nm, "flush_cnt", flush_cnt, x.fl);
      end
    end
  end

  // Push the expectation for the current cycle, then advance one cycle.
  task automatic vec(input string nm, input logic [6:0] c, input logic [1:0] fa,
                     input logic [1:0] fb, input logic e, input int st, input int fl);
    exp_t x;
    x.nm = nm; x.c = c; x.fa = fa; x.fb = fb; x.e = e; x.st = st; x.fl = fl;
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0; ex_branch_taken = 0;
    mem_rd = 0; mem_reg_write = 0; mem_mem_read = 0; dmem_ready = 1;
    wb_rd = 0; wb_reg_write = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    @(posedge clk);
    #1;
    // Reset overrides a live load-use and a forwarding match; no stall counted.
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    ex_rs1 = 3; mem_rd = 3; mem_reg_write = 1;
    for (int i = 0; i < 3; i++) vec("rst_force", C_RST, 2'b00, 2'b00, 0, 0, 0);
    reset = 1'b1;
    idle();
    vec("idle0", C_NORM, 2'b00, 2'b00, 0, 0, 0);

    // Load-use on rs1: one bubble, then the bubble in EX clears it.
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    vec("lu_rs1", C_LU, 2'b00, 2'b00, 0, 0, 0);
    idle();
    vec("lu_bubble", C_NORM, 2'b00, 2'b00, 0, 1, 0);
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    vec("lu_x0", C_NORM, 2'b00, 2'b00, 0, 1, 0);
    idle();
    ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_rs2 = 7; id_uses_rs2 = 1;
    vec("lu_rs2", C_LU, 2'b00, 2'b00, 0, 1, 0);
    id_uses_rs2 = 0;
    vec("lu_unused", C_NORM, 2'b00, 2'b00, 0, 2, 0);
    idle();

    // Forwarding priority and x0 guard.
    mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 3; ex_rs2 = 4;
    vec("fwd_mem", C_NORM, 2'b10, 2'b00, 0, 2, 0);
    mem_reg_write = 0;
    vec("fwd_wb", C_NORM, 2'b01, 2'b00, 0, 2, 0);
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    vec("fwd_x0", C_NORM, 2'b00, 2'b00, 0, 2, 0);
    mem_rd = 4; wb_rd = 6; ex_rs1 = 6; ex_rs2 = 4;
    vec("fwd_both", C_NORM, 2'b01, 2'b10, 0, 2, 0);
    idle();

    // Branch beats load-use: flush counted, stall not.
    ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    vec("br_over_lu", C_BR, 2'b00, 2'b00, 0, 2, 0);
    idle();
    vec("after_br", C_NORM, 2'b00, 2'b00, 0, 2, 1);

    // Three-cycle dmem wait with a pending branch held frozen.
    mem_mem_read = 1; dmem_ready = 0; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) vec("wait3", C_FRZ, 2'b00, 2'b00, 0, 2 + i, 1);
    dmem_ready = 1;
    vec("wait3_ready", C_BR, 2'b00, 2'b00, 0, 5, 1);
    idle();
    vec("after_wait3", C_NORM, 2'b00, 2'b00, 0, 5, 2);

    // Two 10-cycle waits back to back: wait count must clear between them.
    mem_mem_read = 1;
    for (int w = 0; w < 2; w++) begin
      dmem_ready = 0;
      for (int i = 0; i < 10; i++) vec("wait10", C_FRZ, 2'b00, 2'b00, 0, 5 + w*10 + i, 2);
      dmem_ready = 1;
      vec("wait10_ready", C_NORM, 2'b00, 2'b00, 0, 15 + w*10, 2);
    end
    idle();
    vec("after_wait10", C_NORM, 2'b00, 2'b00, 0, 25, 2);

    // Watchdog: 16 not-ready cycles then ERR, absorbing.
    mem_mem_read = 1; dmem_ready = 0;
    for (int i = 0; i < 16; i++) vec("timeout", C_FRZ, 2'b00, 2'b00, 0, 25 + i, 2);
    dmem_ready = 1;
    vec("err_ready", C_FRZ, 2'b00, 2'b00, 1, 41, 2);
    idle();
    ex_branch_taken = 1;
    vec("err_hold", C_FRZ, 2'b00, 2'b00, 1, 42, 2);
    idle();

    // Reset out of ERR clears everything immediately.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) vec("rst_err", C_RST, 2'b00, 2'b00, 0, 0, 0);
    reset = 1'b1;
    vec("post_rst_err", C_NORM, 2'b00, 2'b00, 0, 0, 0);

    // Reset mid-WAIT.
    mem_mem_read = 1; dmem_ready = 0;
    vec("wait_pre_rst0", C_FRZ, 2'b00, 2'b00, 0, 0, 0);
    vec("wait_pre_rst1", C_FRZ, 2'b00, 2'b00, 0, 1, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) vec("rst_wait", C_RST, 2'b00, 2'b00, 0, 0, 0);
    idle();
    reset = 1'b1;
    vec("post_rst_wait", C_NORM, 2'b00, 2'b00, 0, 0, 0);

    @(negedge clk);
    cmp("end", "sbq_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
